// File: rtl/fixed_pred_pkg.sv
// fixed_pred_pkg: FLAC fixed-predictor coefficients and the shift-add prediction sum.
package fixed_pred_pkg;

    localparam int MAX_ORDER = 4;
    // Wide enough for the largest supported sample (32 bits) plus four guard bits.
    localparam int PRED_W = 36;

    localparam int COEF [0:MAX_ORDER][0:3] = '{
        '{0,  0, 0,  0},
        '{1,  0, 0,  0},
        '{2, -1, 0,  0},
        '{3, -3, 1,  0},
        '{4, -6, 4, -1}
    };

    // Constant multiply as shift-add; all coefficient magnitudes fit in 3 bits.
    function automatic logic signed [PRED_W-1:0] cmul(input logic signed [PRED_W-1:0] x, input int c);
        logic signed [PRED_W-1:0] acc;
        int a;
        a = (c < 0) ? -c : c;
        acc = '0;
        for (int i = 0; i < 3; i++)
            if (a[i]) acc = acc + (x <<< i);
        return (c < 0) ? -acc : acc;
    endfunction

    function automatic logic signed [PRED_W-1:0] pred_sum(
        input logic [2:0]               order,
        input logic signed [PRED_W-1:0] h0, h1, h2, h3
    );
        logic signed [PRED_W-1:0] h [4];
        logic signed [PRED_W-1:0] p;
        h = '{h0, h1, h2, h3};
        p = '0;
        for (int k = 0; k <= MAX_ORDER; k++)
            if (order == 3'(k))
                for (int j = 0; j < 4; j++) p = p + cmul(h[j], COEF[k][j]);
        return p;
    endfunction

endpackage

// File: rtl/fixed_pred_hist.sv
// fixed_pred_hist: per-channel order, warmup count and sample history with one write-back port.
module fixed_pred_hist #(
    parameter int SAMPLE_W = 24,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CH_W-1:0]          rd_ch_i,
    output logic [2:0]               rd_order_o,
    output logic [2:0]               rd_warm_o,
    output logic [3:0][SAMPLE_W-1:0] rd_h_o,
    input  logic                     we_i,
    input  logic [CH_W-1:0]          wr_ch_i,
    input  logic [2:0]               wr_order_i,
    input  logic [2:0]               wr_warm_i,
    input  logic [3:0][SAMPLE_W-1:0] wr_h_i
);

    logic [2:0]               order_q [CHANNELS];
    logic [2:0]               warm_q  [CHANNELS];
    logic [3:0][SAMPLE_W-1:0] h_q     [CHANNELS];
    logic                     rd_ok, wr_ok;

    // Channel codes beyond CHANNELS read as an empty order-0 channel and are never stored.
    assign rd_ok      = 32'(rd_ch_i) < CHANNELS;
    assign wr_ok      = 32'(wr_ch_i) < CHANNELS;
    assign rd_order_o = rd_ok ? order_q[rd_ch_i] : '0;
    assign rd_warm_o  = rd_ok ? warm_q[rd_ch_i] : '0;
    assign rd_h_o     = rd_ok ? h_q[rd_ch_i] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                order_q[c] <= '0;
                warm_q[c]  <= '0;
                h_q[c]     <= '0;
            end
        end else if (we_i && wr_ok) begin
            order_q[wr_ch_i] <= wr_order_i;
            warm_q[wr_ch_i]  <= wr_warm_i;
            h_q[wr_ch_i]     <= wr_h_i;
        end
    end

endmodule

// File: rtl/fixed_predictor_decoder_mc.sv
// fixed_predictor_decoder_mc: multi-channel FLAC FIXED-subframe sample reconstruction
// with valid/ready handshakes and one registered output stage.
module fixed_predictor_decoder_mc
    import fixed_pred_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int CHANNELS = 2,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iBlockStart,
    input  logic [3:0]                 iOrder,
    input  logic [CH_W-1:0]            iChannel,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic signed [SAMPLE_W-1:0] iResidual,
    output logic                       oValid,
    input  logic                       iReady,
    output logic signed [SAMPLE_W-1:0] oSample,
    output logic [CH_W-1:0]            oChannel,
    output logic                       oOverflow,
    output logic                       oOrderErr
);

    localparam int ACC_W = SAMPLE_W + 4;

    logic                       valid_q, valid_d, ovf_q, ovf_d, err_q, err_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic [CH_W-1:0]            chan_q, chan_d;
    logic [2:0]                 rd_order, rd_warm, cur_order, cur_warm, wr_warm;
    logic [3:0][SAMPLE_W-1:0]   rd_h, cur_h, wr_h;
    logic                       accept, warmup, ovf, bad_order;
    logic signed [ACC_W-1:0]    pred, full;
    logic signed [SAMPLE_W-1:0] out;

    assign oReady    = !valid_q || iReady;
    assign accept    = iValid && oReady;
    assign bad_order = iOrder > 4'(MAX_ORDER);
    assign oValid    = valid_q;
    assign oSample   = sample_q;
    assign oChannel  = chan_q;
    assign oOverflow = ovf_q;
    assign oOrderErr = err_q;

    // A block start decodes its own beat against the freshly cleared channel state.
    always_comb begin
        cur_order = iBlockStart ? (bad_order ? 3'd0 : iOrder[2:0]) : rd_order;
        cur_warm  = iBlockStart ? 3'd0 : rd_warm;
        cur_h     = iBlockStart ? '0 : rd_h;
        warmup    = cur_warm < cur_order;
        pred      = ACC_W'(pred_sum(cur_order, PRED_W'($signed(cur_h[0])), PRED_W'($signed(cur_h[1])),
                                    PRED_W'($signed(cur_h[2])), PRED_W'($signed(cur_h[3]))));
        full      = ACC_W'(iResidual) + (warmup ? ACC_W'(0) : pred);
        out       = SAMPLE_W'(full);
        ovf       = full != ACC_W'(out);
        wr_warm   = (accept && warmup) ? cur_warm + 3'd1 : cur_warm;
        wr_h      = accept ? {cur_h[2:0], out} : cur_h;
        valid_d   = accept ? 1'b1 : (iReady ? 1'b0 : valid_q);
        sample_d  = accept ? out : sample_q;
        chan_d    = accept ? iChannel : chan_q;
        ovf_d     = ovf_q || (accept && ovf);
        err_d     = err_q || (iBlockStart && bad_order);
    end

    fixed_pred_hist #(
        .SAMPLE_W(SAMPLE_W),
        .CHANNELS(CHANNELS),
        .CH_W    (CH_W)
    ) u_hist (
        .clk_i     (iClock),
        .rst_i     (iReset),
        .rd_ch_i   (iChannel),
        .rd_order_o(rd_order),
        .rd_warm_o (rd_warm),
        .rd_h_o    (rd_h),
        .we_i      (iBlockStart || accept),
        .wr_ch_i   (iChannel),
        .wr_order_i(cur_order),
        .wr_warm_i (wr_warm),
        .wr_h_i    (wr_h)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            valid_q  <= 1'b0;
            sample_q <= '0;
            chan_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            sample_q <= sample_d;
            chan_q   <= chan_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/fixed_predictor_decoder_mc.md
Name: fixed_predictor_decoder_mc

Overview:
- Reconstructs FLAC FIXED-subframe PCM samples, orders 0-4, from a stream of warmup samples followed by residuals.
- Generalised over sample width and channel count; keeps independent prediction history per channel so interleaved channels share one datapath.
- Sits between the residual (Rice) decoder and the channel decorrelation stage.
- Uses a valid/ready handshake on both sides and one registered output stage.

Parameters:
- SAMPLE_W, 24, signed sample and residual width in bits (supported range 8-32).
- CHANNELS, 2, number of independent channel histories (1-8).
- CH_W, $clog2(CHANNELS) (minimum 1), channel index width.

Ports:
- iClock  in  1  clock.
- iReset  in  1  asynchronous active-high reset.
- iBlockStart  in  1  starts a new subframe on channel iChannel; qualifies iOrder.
- iOrder  in  4  predictor order; sampled only with iBlockStart.
- iChannel  in  CH_W  channel of the current input beat.
- iValid  in  1  input beat valid.
- oReady  out  1  input may be accepted.
- iResidual  in  SAMPLE_W  signed warmup sample or residual.
- oValid  out  1  output beat valid.
- iReady  in  1  downstream accepts output.
- oSample  out  SAMPLE_W  reconstructed signed sample.
- oChannel  out  CH_W  channel of oSample.
- oOverflow  out  1  sticky; prediction sum exceeded SAMPLE_W.
- oOrderErr  out  1  sticky; iOrder > 4 was seen at a block start.

Behaviour:
- Reset (async, iReset=1): oValid=0, oSample=0, oChannel=0, oOverflow=0, oOrderErr=0. All channel histories, warmup counters and orders are cleared to 0.
- Mid-operation reset: any in-flight beat is discarded; nothing is emitted after reset releases until new input arrives.
- Handshake: oReady = !oValid || iReady.
  - Input accepted when iValid && oReady.
  - Output transferred when oValid && iReady.
  - oSample and oChannel are held stable while oValid && !iReady.
- Latency: accept at cycle N produces oValid=1 at cycle N+1.
- Throughput: one sample per cycle per block, with no per-channel restriction; back-to-back beats on the same channel must use the history updated by the previous beat.
- Per-channel state:
  - order[c] (3 bits);
  - warm[c] (3 bits, counts warmup samples taken);
  - history h0..h3, where h0 is the newest sample.
- Block start (iBlockStart=1 and iChannel=c, with or without iValid):
  - order[c] <= iOrder;
  - warm[c] <= 0;
  - h0..h3 of channel c <= 0.
  - If iOrder > 4: order[c] <= 0 and oOrderErr is set.
  - When iValid and oReady are also high in the same cycle, the beat is the first sample of the new block and is decoded against the freshly cleared state.
  - iBlockStart with iValid=0 is accepted regardless of oReady and emits nothing.
- Decode of an accepted beat on channel c (r = iResidual):
  - If warm[c] < order[c]: out = r, then warm[c]++.
  - Otherwise:
    - order 0: out = r;
    - order 1: out = r + h0;
    - order 2: out = r + 2h0 - h1;
    - order 3: out = r + 3h0 - 3h1 + h2;
    - order 4: out = r + 4h0 - 6h1 + 4h2 - h3.
  - History shifts: h3<=h2, h2<=h1, h1<=h0, h0<=out.
- Arithmetic:
  - Computed signed in SAMPLE_W+4 bits.
  - Result truncated (wrap) to SAMPLE_W for oSample and for the history.
  - If the full-width result lies outside the SAMPLE_W signed range, oOverflow is set.
- Sticky flags clear only on reset.
- Beats on channels never block-started decode as order 0 (passthrough).
- Multiplies are by constants and must be implemented as shift-add; no DSP inference is required.

Decomposition:
- Package fixed_pred_pkg holds:
  - MAX_ORDER=4;
  - coefficient constants per order;
  - function pred_sum(order, h0..h3), returning a SAMPLE_W+4 bit result.
- One sub-module, fixed_pred_hist: a per-channel history/order/warm register file with a write-back port.
- The top level holds the handshake, output register and flags.

Test Plan:
- SAMPLE_W=16, ch0, block start with order 2; inputs 10, 20, 0, 0, 5 -> outputs 10, 20, 30, 40, 55 on consecutive cycles with iReady=1.
- Two channels interleaved:
  - ch0 order 1, inputs 5, 1, 1;
  - ch1 order 0, inputs 7, -3;
  - sent alternately ch0/ch1;
  - -> ch0 outputs 5, 6, 7 and ch1 outputs 7, -3, with oChannel matching each beat.
- Back-pressure:
  - order 1 stream 1, 1, 1, 1 with iReady held low for 3 cycles after the first output;
  - -> oReady=0 while stalled, oSample held at 1, and the eventual outputs are 1, 2, 3, 4 with no loss or duplication.
- Order 4, warmup 1, 2, 3, 4, residual 0 -> 5, then residual 0 -> 6 (linear extrapolation); a following iBlockStart with order 3 resets history so the first new input passes through unchanged.
- Overflow and error, SAMPLE_W=16:
  - order 1, inputs 32767, 1 -> second output -32768 and oOverflow=1.
  - Block start with iOrder=7 -> oOrderErr=1 and that block behaves as order 0.
- Assert iReset mid-block while oValid=1 -> oValid, oSample and the flags go to 0 immediately; after release a new order-1 block starting with 9 outputs 9 (history was cleared).
